// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: two writeback requesters, issue/decode hazard lookup, and the registered
// register-file write port.
interface rf_wb_arbiter_if;
   logic        p0_valid;
   logic [4:0]  p0_rd;
   logic [31:0] p0_data;
   logic        p0_stall;
   logic        p1_valid;
   logic [4:0]  p1_rd;
   logic [31:0] p1_data;
   logic        p1_ready;
   logic        iss_valid;
   logic [4:0]  iss_rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        hazard;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata;

   modport master (
      output p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data,
             iss_valid, iss_rd, rs1, rs2,
      input  p0_stall, p1_ready, hazard, rf_we, rf_rd, rf_wdata
   );

   modport slave (
      input  p0_valid, p0_rd, p0_data, p1_valid, p1_rd, p1_data,
             iss_valid, iss_rd, rs1, rs2,
      output p0_stall, p1_ready, hazard, rf_we, rf_rd, rf_wdata
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter with a busy scoreboard for long-latency results.
// Define RF_ARB_STARVE_GUARD_EN to enable the port-1 starvation guard (forced grant).
module rf_wb_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   rf_wb_arbiter_if.slave bus
);

   logic [31:0] busy_q, busy_d;
   logic        rf_we_q, rf_we_d;
   logic [4:0]  rf_rd_q, rf_rd_d;
   logic [31:0] rf_wdata_q, rf_wdata_d;
   logic        p0_eff;
   logic        force_grant;
   logic        p1_grant;
   logic        p0_stall_c;

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
      $error("rf_wb_arbiter: STARVE_LIMIT must be in 1..15");
   end

   // rd==0 requests are accepted but never write, so they do not block port 1
   assign p0_eff     = bus.p0_valid && (bus.p0_rd != 5'd0);
   assign p1_grant   = bus.p1_valid && (!p0_eff || force_grant);
   assign p0_stall_c = force_grant && bus.p1_valid && p0_eff;

`ifdef RF_ARB_STARVE_GUARD_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
   logic [3:0] starve_q, starve_d;

   assign force_grant = (starve_q == LIMIT);

   always_comb begin
      starve_d = starve_q;
      if (p1_grant) begin
         starve_d = 4'd0;
      end else if (bus.p1_valid && (starve_q != 4'hF)) begin
         starve_d = starve_q + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_q <= 4'd0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign force_grant = 1'b0;
`endif

   always_comb begin
      rf_we_d    = 1'b0;
      rf_rd_d    = rf_rd_q;
      rf_wdata_d = rf_wdata_q;
      if (p1_grant && (bus.p1_rd != 5'd0)) begin
         rf_we_d    = 1'b1;
         rf_rd_d    = bus.p1_rd;
         rf_wdata_d = bus.p1_data;
      end else if (p0_eff && !p0_stall_c) begin
         rf_we_d    = 1'b1;
         rf_rd_d    = bus.p0_rd;
         rf_wdata_d = bus.p0_data;
      end
   end

   // Clear first so a same-edge issue to the same register keeps the bit set
   always_comb begin
      busy_d = busy_q;
      if (p1_grant) begin
         busy_d[bus.p1_rd] = 1'b0;
      end
      if (bus.iss_valid && (bus.iss_rd != 5'd0)) begin
         busy_d[bus.iss_rd] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q     <= 32'd0;
         rf_we_q    <= 1'b0;
         rf_rd_q    <= 5'd0;
         rf_wdata_q <= 32'd0;
      end else begin
         busy_q     <= busy_d;
         rf_we_q    <= rf_we_d;
         rf_rd_q    <= rf_rd_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign bus.hazard   = ((bus.rs1 != 5'd0) && busy_q[bus.rs1]) ||
                         ((bus.rs2 != 5'd0) && busy_q[bus.rs2]);
   assign bus.p1_ready = p1_grant;
   assign bus.p0_stall = p0_stall_c;
   assign bus.rf_we    = rf_we_q;
   assign bus.rf_rd    = rf_rd_q;
   assign bus.rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected register-file writes are queued at issue time and
// popped by a monitor whenever rf_we is seen; handshake and hazard outputs are checked inline.
module tb_rf_wb_arbiter;
   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   rf_wb_arbiter_if bus();

   rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  n_pass  = 0;
   int  n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic push(input logic [4:0] rd, input logic [31:0] data);
      wr_t w;
      w.rd   = rd;
      w.data = data;
      exp_q.push_back(w);
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.p0_valid  = 1'b0;
      bus.p0_rd     = 5'd0;
      bus.p0_data   = 32'd0;
      bus.p1_valid  = 1'b0;
      bus.p1_rd     = 5'd0;
      bus.p1_data   = 32'd0;
      bus.iss_valid = 1'b0;
      bus.iss_rd    = 5'd0;
      bus.rs1       = 5'd0;
      bus.rs2       = 5'd0;
   endtask

   task automatic drive_p0(input logic [4:0] rd, input logic [31:0] data);
      bus.p0_valid = 1'b1;
      bus.p0_rd    = rd;
      bus.p0_data  = data;
   endtask

   task automatic drive_p1(input logic [4:0] rd, input logic [31:0] data);
      bus.p1_valid = 1'b1;
      bus.p1_rd    = rd;
      bus.p1_data  = data;
   endtask

   // Monitor: every registered write must match the oldest queued expectation
   always @(negedge clk) begin
      wr_t e;
      if (reset_n && bus.rf_we) begin
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL wb_unexpected: rf_we=1 rd=%0d data=0x%0h, expected no write",
                     bus.rf_rd, bus.rf_wdata);
         end else begin
            e = exp_q.pop_front();
            chk("wb_rd", 32'(bus.rf_rd), 32'(e.rd));
            chk("wb_data", bus.rf_wdata, e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, expected bench completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic forced;
      idle();
      reset_n = 1'b0;
      #2;
      chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
      chk("rst_rf_rd", 32'(bus.rf_rd), 32'd0);
      chk("rst_rf_wdata", bus.rf_wdata, 32'd0);
      chk("rst_hazard", 32'(bus.hazard), 32'd0);
      chk("rst_p1_ready", 32'(bus.p1_ready), 32'd0);
      chk("rst_p0_stall", 32'(bus.p0_stall), 32'd0);
      #5;
      reset_n = 1'b1;
      next_cyc();

      // p0 write, port 1 idle
      drive_p0(5'd5, 32'hDEADBEEF);
      push(5'd5, 32'hDEADBEEF);
      #2;
      chk("p0_only_stall", 32'(bus.p0_stall), 32'd0);
      chk("p0_only_p1_ready", 32'(bus.p1_ready), 32'd0);
      next_cyc();
      idle();

      // p0 rd=0 does not block port 1
      drive_p0(5'd0, 32'h0BAD_0000);
      drive_p1(5'd3, 32'h0000_0033);
      push(5'd3, 32'h0000_0033);
      #2;
      chk("rd0_p1_ready", 32'(bus.p1_ready), 32'd1);
      chk("rd0_p0_stall", 32'(bus.p0_stall), 32'd0);
      next_cyc();
      idle();

      // default priority: p0 first, then p1
      drive_p0(5'd10, 32'hAAAA_000A);
      drive_p1(5'd11, 32'hBBBB_000B);
      push(5'd10, 32'hAAAA_000A);
      #2;
      chk("prio_p1_denied", 32'(bus.p1_ready), 32'd0);
      next_cyc();
      bus.p0_valid = 1'b0;
      push(5'd11, 32'hBBBB_000B);
      #2;
      chk("prio_p1_granted", 32'(bus.p1_ready), 32'd1);
      next_cyc();
      idle();

      // p1 rd=0: accepted, no write
      drive_p1(5'd0, 32'h1234_5678);
      #2;
      chk("p1_rd0_ready", 32'(bus.p1_ready), 32'd1);
      next_cyc();
      idle();

      // scoreboard set / hazard / clear on p1 acceptance
      bus.iss_valid = 1'b1;
      bus.iss_rd    = 5'd7;
      bus.rs1       = 5'd7;
      #2;
      chk("haz_before_set", 32'(bus.hazard), 32'd0);
      next_cyc();
      bus.iss_valid = 1'b0;
      #2;
      chk("haz_rs1", 32'(bus.hazard), 32'd1);
      bus.rs1 = 5'd0;
      bus.rs2 = 5'd7;
      #1;
      chk("haz_rs2", 32'(bus.hazard), 32'd1);
      next_cyc();
      drive_p1(5'd7, 32'h0000_0077);
      push(5'd7, 32'h0000_0077);
      #2;
      chk("haz_p1_accept", 32'(bus.p1_ready), 32'd1);
      chk("haz_held_until_edge", 32'(bus.hazard), 32'd1);
      next_cyc();
      bus.p1_valid = 1'b0;
      #2;
      chk("haz_cleared", 32'(bus.hazard), 32'd0);
      next_cyc();
      idle();

      // same-edge set and clear of r9: set wins
      bus.iss_valid = 1'b1;
      bus.iss_rd    = 5'd9;
      next_cyc();
      drive_p1(5'd9, 32'h0000_0099);
      push(5'd9, 32'h0000_0099);
      #2;
      chk("setwin_p1_ready", 32'(bus.p1_ready), 32'd1);
      next_cyc();
      idle();
      bus.rs1 = 5'd9;
      #2;
      chk("setwin_busy_kept", 32'(bus.hazard), 32'd1);
      drive_p1(5'd9, 32'h0000_0999);
      push(5'd9, 32'h0000_0999);
      next_cyc();
      idle();
      bus.rs1 = 5'd9;
      #2;
      chk("setwin_cleared", 32'(bus.hazard), 32'd0);
      next_cyc();
      idle();

      // both ports requesting every cycle
      for (int i = 1; i <= 6; i++) begin
`ifdef RF_ARB_STARVE_GUARD_EN
         forced = (i == LIMIT + 1);
`else
         forced = 1'b0;
`endif
         drive_p0(5'd12, 32'h1000_0000 + 32'(i));
         drive_p1(5'd13, 32'h2000_0000 + 32'(i));
         if (forced) push(5'd13, 32'h2000_0000 + 32'(i));
         else push(5'd12, 32'h1000_0000 + 32'(i));
         #2;
         chk($sformatf("starve_p1_ready_c%0d", i), 32'(bus.p1_ready), 32'(forced));
         chk($sformatf("starve_p0_stall_c%0d", i), 32'(bus.p0_stall), 32'(forced));
         next_cyc();
      end
      idle();
      next_cyc();

      // asynchronous reset mid-stream
      bus.iss_valid = 1'b1;
      bus.iss_rd    = 5'd20;
      next_cyc();
      bus.iss_valid = 1'b0;
      bus.rs1       = 5'd20;
      drive_p0(5'd14, 32'hCAFE_0014);
      next_cyc();
      bus.p0_valid = 1'b0;
      #1;
      chk("prerst_rf_we", 32'(bus.rf_we), 32'd1);
      chk("prerst_hazard", 32'(bus.hazard), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("async_rst_rf_we", 32'(bus.rf_we), 32'd0);
      chk("async_rst_hazard", 32'(bus.hazard), 32'd0);
      chk("async_rst_rf_rd", 32'(bus.rf_rd), 32'd0);
      chk("async_rst_rf_wdata", bus.rf_wdata, 32'd0);
      idle();
      #3;
      reset_n = 1'b1;
      next_cyc();
      drive_p0(5'd14, 32'hCAFE_0014);
      push(5'd14, 32'hCAFE_0014);
      #2;
      chk("post_rst_p0_stall", 32'(bus.p0_stall), 32'd0);
      next_cyc();
      idle();
      next_cyc();
      next_cyc();

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
